// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-file access arbiter.
package reg_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  // Width of a requester index (host, cmd, dat fit in two bits).
  localparam int GRANT_W = 2;

  localparam logic [GRANT_W-1:0] REQ_HOST = 2'd0;
  localparam logic [GRANT_W-1:0] REQ_CMD  = 2'd1;
  localparam logic [GRANT_W-1:0] REQ_DAT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// granted requester and wraps, so every pending requester is reached
// within NUM_REQ grants.
module rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] last_i,
  output logic [GRANT_W-1:0] grant_o,
  output logic               valid_o
);

  // Walk the candidates in priority order and keep the first requester found.
  always_comb begin
    int                 cand;
    logic [GRANT_W-1:0] idx;
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    grant_o = '0;
    valid_o = 1'b0;
    cand    = 0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      idx = GRANT_W'(cand);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// Serialises host/cmd/dat accesses onto the single register-file port:
// one req pulse per transaction, bounded wait for reg_ack, one-cycle
// ack/err back to the granted requester.
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int NUM_REQ     = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            rw_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [NUM_REQ-1:0]            err_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          busy_o,
  output logic [GRANT_W-1:0]            grant_o,
  output logic                          reg_req,
  output logic                          reg_rw,
  output logic [ADDR_WIDTH-1:0]         reg_addr,
  output logic [DATA_WIDTH-1:0]         reg_data_in,
  input  logic [DATA_WIDTH-1:0]         reg_data_out,
  input  logic                          reg_ack
);

  localparam int                CNT_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(ACK_TIMEOUT);
  // Pointer value that makes the host win the first arbitration.
  localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(NUM_REQ - 1);

  state_e                 state_q, state_d;
  logic [GRANT_W-1:0]     last_q,  last_d;
  logic [GRANT_W-1:0]     grant_q, grant_d;
  logic                   rw_q,    rw_d;
  logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic                   err_q,   err_d;

  logic [GRANT_W-1:0]     arb_grant;
  logic                   arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i   (req_i),
    .last_i  (last_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      grant_q <= REQ_HOST;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Sequencer: grant and latch in IDLE, pulse in ISSUE, bounded wait, report.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          rw_d    = rw_i[arb_grant];
          addr_d  = addr_i[arb_grant*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = wdata_i[arb_grant*DATA_WIDTH +: DATA_WIDTH];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The counter only advances below its limit, so it saturates.
        if (reg_ack) begin
          rdata_d = reg_data_out;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Completion pulses go only to the requester that owns the transaction.
  always_comb begin
    ack_o = '0;
    err_o = '0;
    if (state_q == ST_DONE) begin
      ack_o[grant_q] = 1'b1;
      err_o[grant_q] = err_q;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign grant_o     = grant_q;
  assign rdata_o     = rdata_q;
  assign reg_req     = (state_q == ST_ISSUE);
  assign reg_rw      = rw_q;
  assign reg_addr    = addr_q;
  assign reg_data_in = wdata_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter: a table of single transactions followed
// by hand-written multi-cycle sequences (round robin, timeout, reset, drop).
module tb_reg_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_i = '0;
  logic [NR-1:0]    rw_i = '0;
  logic [NR*AW-1:0] addr_i = '0;
  logic [NR*DW-1:0] wdata_i = '0;
  logic [NR-1:0]    ack_o, err_o;
  logic [DW-1:0]    rdata_o;
  logic             busy_o;
  logic [1:0]       grant_o;
  logic             reg_req, reg_rw, reg_ack;
  logic [AW-1:0]    reg_addr;
  logic [DW-1:0]    reg_data_in, reg_data_out;

  // Register-file model: acknowledges one cycle after the req pulse.
  logic          rf_en = 1'b1;
  logic [DW-1:0] rf_rdata = '0;
  logic          rf_ack_q = 1'b0;
  always @(posedge clk) rf_ack_q <= rf_en & reg_req;
  assign reg_ack      = rf_ack_q;
  assign reg_data_out = rf_rdata;

  reg_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_i(req_i), .rw_i(rw_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .grant_o(grant_o), .reg_req(reg_req), .reg_rw(reg_rw),
    .reg_addr(reg_addr), .reg_data_in(reg_data_in),
    .reg_data_out(reg_data_out), .reg_ack(reg_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]       req;
    logic [2:0]       rw;
    logic [2:0][4:0]  addr;
    logic [2:0][31:0] wdata;
    logic [31:0]      rf;
    logic [1:0]       g;     // hand-computed round-robin winner
  } vec_t;

  vec_t tbl[8];

  // One transaction from IDLE with the nominal register file:
  // cycle 0 IDLE, 1 ISSUE, 2 WAIT(reg_ack), 3 DONE.
  task automatic do_txn(input vec_t v, input string tag);
    @(posedge clk); #1;
    req_i = v.req; rw_i = v.rw; addr_i = v.addr; wdata_i = v.wdata; rf_rdata = v.rf;
    @(negedge clk);
    check($sformatf("%s c0 busy", tag), 32'(busy_o), 32'd0);
    @(negedge clk);
    check($sformatf("%s c1 reg_req", tag), 32'(reg_req), 32'd1);
    check($sformatf("%s c1 grant", tag), 32'(grant_o), 32'(v.g));
    check($sformatf("%s c1 reg_rw", tag), 32'(reg_rw), 32'(v.rw[v.g]));
    check($sformatf("%s c1 reg_addr", tag), 32'(reg_addr), 32'(v.addr[v.g]));
    check($sformatf("%s c1 reg_data_in", tag), reg_data_in, v.wdata[v.g]);
    @(negedge clk);
    check($sformatf("%s c2 reg_req", tag), 32'(reg_req), 32'd0);
    @(negedge clk);
    check($sformatf("%s c3 ack", tag), 32'(ack_o), 32'd1 << v.g);
    check($sformatf("%s c3 err", tag), 32'(err_o), 32'd0);
    check($sformatf("%s c3 rdata", tag), rdata_o, v.rf);
    req_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n_ack, prev_c, ack_c, pulses;
    vec_t v;

    // Fields: req, rw, {dat,cmd,host} addr, {dat,cmd,host} wdata, rf data, winner.
    tbl[0] = '{3'b001, 3'b001, {5'h00, 5'h00, 5'h03}, {32'h0, 32'h0, 32'h0},
               32'hDEAD_BEEF, 2'd0};
    tbl[1] = '{3'b010, 3'b000, {5'h00, 5'h04, 5'h00}, {32'h0, 32'h1234_5678, 32'h0},
               32'hCAFE_0001, 2'd1};
    tbl[2] = '{3'b111, 3'b111, {5'h1F, 5'h02, 5'h01},
               {32'hA5A5_A5A5, 32'h1111_1111, 32'h2222_2222}, 32'h0BAD_F00D, 2'd2};
    tbl[3] = '{3'b011, 3'b010, {5'h1E, 5'h0C, 5'h0A},
               {32'h3333_3333, 32'h4444_4444, 32'h5555_5555}, 32'h1357_2468, 2'd0};
    tbl[4] = '{3'b101, 3'b001, {5'h15, 5'h0B, 5'h10},
               {32'h6666_6666, 32'h7777_7777, 32'h8888_8888}, 32'h2468_ACE0, 2'd2};
    tbl[5] = '{3'b110, 3'b100, {5'h08, 5'h09, 5'h11},
               {32'h9999_9999, 32'hAAAA_AAAA, 32'hBBBB_BBBB}, 32'hFFFF_0000, 2'd1};
    tbl[6] = '{3'b001, 3'b001, {5'h00, 5'h00, 5'h1D}, {32'h0, 32'h0, 32'h0},
               32'h0000_FFFF, 2'd0};
    tbl[7] = '{3'b100, 3'b000, {5'h05, 5'h00, 5'h00}, {32'hC0FF_EE00, 32'h0, 32'h0},
               32'h0000_0001, 2'd2};

    // Reset state.
    #12;
    check("rst ack", 32'(ack_o), 32'd0);
    check("rst err", 32'(err_o), 32'd0);
    check("rst rdata", rdata_o, 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst grant", 32'(grant_o), 32'd0);
    check("rst reg_req", 32'(reg_req), 32'd0);
    check("rst reg_addr", 32'(reg_addr), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    foreach (tbl[i]) do_txn(tbl[i], $sformatf("vec%0d", i));

    // All three requesting continuously from reset: 0,1,2,0,1,2, 4 cycles apart.
    @(negedge clk); reset_n = 1'b0;
    req_i = 3'b111; rw_i = 3'b111; rf_rdata = 32'h5555_AAAA;
    @(negedge clk); reset_n = 1'b1;
    n_ack = 0; prev_c = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack_o != '0) begin
        check("rr onehot", $countones(ack_o), 32'd1);
        if (n_ack < 6) check($sformatf("rr order %0d", n_ack), 32'(ack_o), 32'd1 << (n_ack % 3));
        if (n_ack > 0 && n_ack < 6) check("rr spacing", 32'(c - prev_c), 32'd4);
        prev_c = c;
        n_ack++;
      end
    end
    check("rr ack count >= 6", 32'(n_ack >= 6), 32'd1);
    req_i = '0;
    repeat (8) @(negedge clk);
    check("rr idle after", 32'(busy_o), 32'd0);

    // Timeout: no reg_ack, host read; ack/err at cycle ACK_TIMEOUT+3.
    rf_en = 1'b0;
    @(posedge clk); #1;
    req_i = 3'b001; rw_i = 3'b001; addr_i = '0; addr_i[4:0] = 5'h06;
    ack_c = -1; pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (reg_req) pulses++;
      if (ack_o != '0 && ack_c < 0) begin
        ack_c = c;
        check("to ack", 32'(ack_o), 32'b001);
        check("to err", 32'(err_o), 32'b001);
        check("to rdata", rdata_o, 32'd0);
        req_i = '0;
      end
    end
    check("to ack cycle", 32'(ack_c), 32'(TO + 3));
    check("to req pulses", 32'(pulses), 32'd1);
    rf_en = 1'b1;
    v = '{3'b001, 3'b001, {5'h00, 5'h00, 5'h07}, {32'h0, 32'h0, 32'h0}, 32'h600D_0001, 2'd0};
    do_txn(v, "after_to");

    // Host drops req_i during WAIT: ack still issued, only one reg_req.
    @(posedge clk); #1;
    req_i = 3'b001; rw_i = 3'b000; addr_i = '0; addr_i[4:0] = 5'h09;
    rf_rdata = 32'h7777_0000;
    ack_c = -1; pulses = 0; n_ack = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (reg_req) pulses++;
      if (ack_o != '0) begin
        n_ack++;
        ack_c = c;
        check("drop ack", 32'(ack_o), 32'b001);
      end
      if (c == 2) begin
        check("drop in wait busy", 32'(busy_o), 32'd1);
        req_i = '0;
      end
    end
    check("drop ack cycle", 32'(ack_c), 32'd3);
    check("drop ack count", 32'(n_ack), 32'd1);
    check("drop req pulses", 32'(pulses), 32'd1);

    // Reset during WAIT of a dat write; host pending wins after release.
    rf_en = 1'b0;
    @(posedge clk); #1;
    req_i = 3'b100; rw_i = 3'b000; addr_i = {5'h1A, 5'h00, 5'h12};
    wdata_i = {32'h0D0D_0D0D, 32'h0, 32'h0E0E_0E0E};
    repeat (3) @(negedge clk);
    check("rstw busy", 32'(busy_o), 32'd1);
    check("rstw reg_addr", 32'(reg_addr), 32'h1A);
    req_i = 3'b101;
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rstw ack", 32'(ack_o), 32'd0);
    check("rstw err", 32'(err_o), 32'd0);
    check("rstw rdata", rdata_o, 32'd0);
    check("rstw busy0", 32'(busy_o), 32'd0);
    check("rstw grant", 32'(grant_o), 32'd0);
    check("rstw reg_req", 32'(reg_req), 32'd0);
    check("rstw reg_addr0", 32'(reg_addr), 32'd0);
    check("rstw reg_data_in", reg_data_in, 32'd0);
    @(negedge clk);
    check("rstw held ack", 32'(ack_o), 32'd0);
    rf_en = 1'b1; rf_rdata = 32'h0123_4567;
    #2 reset_n = 1'b1;
    ack_c = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (reg_req) begin
        check("rstw first grant", 32'(grant_o), 32'd0);
        check("rstw host addr", 32'(reg_addr), 32'h12);
      end
      if (ack_o != '0 && ack_c < 0) begin
        ack_c = c;
        check("rstw host ack", 32'(ack_o), 32'b001);
        check("rstw host rdata", rdata_o, 32'h0123_4567);
        req_i = '0;
      end
    end
    check("rstw ack seen", 32'(ack_c >= 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
# reg_arbiter

Sequencer and round-robin arbiter that shares the single 32-bit register-file access port (req/rw/addr/data_in → data_out/ack) between three requesters: the host CPU bus, the command-line engine and the data-line engine. It serialises requests, drives exactly one single-cycle `req` pulse per transaction into the register file, and captures the read data. It returns a one-cycle `ack` (plus `err` on timeout) to the granted requester. It sits between the host interface and the SD register file.

## Interface
- `DATA_WIDTH`, 32, register word width
- `ADDR_WIDTH`, 5, register index width
- `NUM_REQ`, 3, number of requesters (0 = host, 1 = cmd, 2 = dat)
- `ACK_TIMEOUT`, 15, cycles waited for `reg_ack` before aborting
- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_i`  in  NUM_REQ  per-requester request, held until its `ack_o`
- `rw_i`  in  NUM_REQ  per-requester direction, 1 = read, 0 = write
- `addr_i`  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`
- `wdata_i`  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- `ack_o`  out  NUM_REQ  one-cycle completion pulse to granted requester
- `err_o`  out  NUM_REQ  one-cycle timeout flag, coincident with `ack_o`
- `rdata_o`  out  DATA_WIDTH  read data, valid while `ack_o` is high, held afterwards
- `busy_o`  out  1  high in any state other than IDLE
- `grant_o`  out  2  index of the current or last granted requester
- `reg_req`  out  1  request to register file
- `reg_rw`  out  1  direction to register file
- `reg_addr`  out  ADDR_WIDTH  address to register file
- `reg_data_in`  out  DATA_WIDTH  write data to register file
- `reg_data_out`  in  DATA_WIDTH  read data from register file
- `reg_ack`  in  1  register file acknowledge

## Operation
- States: IDLE → ISSUE → WAIT → DONE → IDLE.
- IDLE: if any `req_i` is set, pick the winner by round-robin. Search starts at `(last_grant+1) mod NUM_REQ`. Latch the winner's rw/addr/wdata into `reg_rw/reg_addr/reg_data_in` and go to ISSUE. Requests that arrive while not in IDLE are deferred, never dropped.
- ISSUE: `reg_req`=1 for exactly this one cycle, then go to WAIT and clear the timeout counter.
- WAIT: `reg_req`=0. When `reg_ack` is seen, capture `reg_data_out` into `rdata_o` (on writes too) and go to DONE. Otherwise increment the counter. When the counter reaches ACK_TIMEOUT, go to DONE with the error flag set and `rdata_o`=0.
- DONE: `ack_o[grant]`=1, and `err_o[grant]`=1 if timed out. Update the round-robin pointer to `grant`, then go to IDLE.
- `reg_rw/reg_addr/reg_data_in` stay stable from ISSUE until the next grant.
- A requester that drops `req_i` mid-transaction does not abort it. The transaction completes and the `ack_o` pulse is still issued.
- If `req_i` is still high in the cycle after `ack_o`, it is a new request.
- Timeout counter width is `$clog2(ACK_TIMEOUT+1)`. It saturates and does not wrap.

## Timing
- Reset values: state IDLE, all outputs 0, pointer such that requester 0 wins first, `grant_o`=0, counter 0.
- Reset asserted mid-transaction: return to IDLE immediately. No `ack_o` is issued for the aborted access, and pending requests are re-arbitrated after release.
- Latency, nominal register file (ack one cycle after the `req` edge):
  - `req_i` high in cycle 0 (IDLE);
  - ISSUE in cycle 1;
  - `reg_ack` in cycle 2;
  - DONE/`ack_o` in cycle 3.
  - Total: 3 cycles.
- Next IDLE is cycle 4. Back-to-back transactions run every 4 cycles.
- Timeout path: `ack_o`/`err_o` arrive ACK_TIMEOUT+2 cycles after ISSUE.
- Simultaneous requests: exactly one `ack_o` bit is high in any cycle. Fairness guarantees each pending requester is served within NUM_REQ transactions.
- `reg_ack` arriving in IDLE or DONE (stale) is ignored.

## Structure
- Package `reg_arb_pkg`:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3);
  - requester index constants REQ_HOST=0, REQ_CMD=1, REQ_DAT=2;
  - default DATA_WIDTH/ADDR_WIDTH.
- One sub-module, `rr_arbiter`: combinational round-robin grant from `req` vector and last-grant pointer, outputs grant index and valid. The FSM, latching, and timeout logic live in `reg_arbiter`.

## Test plan
- Single host read, addr 5'h03, register file returns 32'hDEAD_BEEF → `reg_req` pulses in cycle 1 only; `ack_o`=3'b001 and `rdata_o`=32'hDEAD_BEEF in cycle 3; `err_o`=0.
- Cmd write, addr 5'h04, data 32'h1234_5678 → `reg_rw`=0, `reg_addr`=5'h04, `reg_data_in`=32'h1234_5678 during ISSUE; `ack_o`=3'b010.
- All three `req_i` held high continuously from reset → grant order 0,1,2,0,1,2; each `ack_o` 4 cycles apart.
- `reg_ack` tied 0, host read → `ack_o[0]` and `err_o[0]` at cycle ACK_TIMEOUT+3 (18 with defaults); `rdata_o`=0; next request is served normally.
- `reset_n` pulled low during WAIT of a dat write → all outputs 0 asynchronously, no `ack_o`; after release, pending host request granted first.
- Host drops `req_i` in WAIT → `ack_o[0]` still pulses in DONE; no spurious second `reg_req`.
